// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-Stream packet switch.
//   arb_mode_e        : arbitration policy selector (round-robin / fixed priority)
//   IDLE / LOCKED     : per-master path state encoding
//   one_hot_to_binary : index of the set bit in a one-hot vector (up to 32 bits)
package axis_switch_pkg;

    typedef enum logic [0:0] {
        ARB_ROUND_ROBIN    = 1'b0,
        ARB_FIXED_PRIORITY = 1'b1
    } arb_mode_e;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // OR-ing the indices is exact for a one-hot input and yields 0 for all-zero.
    function automatic logic [31:0] one_hot_to_binary(input logic [31:0] one_hot);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (one_hot[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when the grant is actually taken.
//   clk, resn : clock, synchronous active-low reset
//   req       : request vector
//   take      : current grant is consumed this cycle
//   grant     : one-hot grant (combinational)
module round_robin_arbiter
    import axis_switch_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         resn,
    input  logic [N-1:0] req,
    input  logic         take,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_reg;
    logic [31:0]   grant_idx;

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant_idx = one_hot_to_binary(32'(grant));

    always_ff @(posedge clk) begin
        if (!resn) begin
            ptr_reg <= '0;
        end else if (take && (|grant)) begin
            ptr_reg <= (grant_idx >= 32'(N - 1)) ? '0 : PW'(grant_idx + 32'd1);
        end
    end

endmodule

// File: rtl/simple_1ck_fifo.sv
// Single-clock FIFO with registered write and the head word presented
// combinationally from storage (first-word fall-through).
//   clk, resn       : clock, synchronous active-low reset (pointers only)
//   wr_en, wr_data  : push (ignored when full)
//   rd_en, rd_data  : pop (ignored when empty), current head word
//   full, empty     : occupancy flags, both registered-state derived
module simple_1ck_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage is not reset; resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/axis_packet_switch.sv
// AXI-Stream crossbar: every slave is buffered in its own FIFO, every master
// has its own arbiter and IDLE/LOCKED path state, so packets to different
// masters flow concurrently. A granted path holds until the tlast beat.
// Heads addressed to a non-existent master are drained and counted.
//   s_axis_*   : per-slave input streams (tid = destination master)
//   m_axis_*   : per-master output streams (tid = source slave)
//   m_busy     : master is locked to a slave
//   drop_count : saturating count of dropped packets
module axis_packet_switch
    import axis_switch_pkg::*;
#(
    parameter int S_PORTS     = 4,
    parameter int M_PORTS     = 4,
    parameter int TID_WIDTH   = 8,
    parameter int TUSER_WIDTH = 8,
    parameter int TDATA_WIDTH = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int ARB_MODE    = 0
) (
    input  logic                           clk,
    input  logic                           resn,
    input  logic [S_PORTS*TID_WIDTH-1:0]   s_axis_tid,
    input  logic [S_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [S_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_PORTS-1:0]             s_axis_tvalid,
    input  logic [S_PORTS-1:0]             s_axis_tlast,
    output logic [S_PORTS-1:0]             s_axis_tready,
    output logic [M_PORTS*TID_WIDTH-1:0]   m_axis_tid,
    output logic [M_PORTS*TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [M_PORTS*TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_PORTS-1:0]             m_axis_tvalid,
    output logic [M_PORTS-1:0]             m_axis_tlast,
    input  logic [M_PORTS-1:0]             m_axis_tready,
    output logic [M_PORTS-1:0]             m_busy,
    output logic [15:0]                    drop_count
);
    localparam int SW     = $clog2(S_PORTS);
    localparam int WORD_W = 1 + TID_WIDTH + TUSER_WIDTH + TDATA_WIDTH;
    localparam int TID_LO = TUSER_WIDTH + TDATA_WIDTH;

    logic [S_PORTS-1:0]           fifo_full;
    logic [S_PORTS-1:0]           fifo_empty;
    logic [S_PORTS-1:0]           fifo_pop;
    logic [S_PORTS-1:0]           head_last;
    logic [S_PORTS-1:0]           slave_locked;
    logic [S_PORTS-1:0]           slave_dropping;
    logic [S_PORTS-1:0]           drop_last;
    logic [S_PORTS*TID_WIDTH-1:0] head_tid;
    logic [WORD_W-1:0]            head_word [S_PORTS];
    logic [M_PORTS-1:0]           m_locked;
    logic [M_PORTS-1:0]           m_accept;
    logic [M_PORTS*SW-1:0]        src_flat;
    logic [15:0]                  drop_count_reg;
    logic [16:0]                  drop_sum;

    assign s_axis_tready = ~fifo_full & {S_PORTS{resn}};
    assign drop_count    = drop_count_reg;

    // ---------------- per-slave ingress and drop logic ----------------
    genvar gi;
    generate
        for (gi = 0; gi < S_PORTS; gi++) begin : g_slave
            logic [WORD_W-1:0] wr_word;
            logic              bad_tid;
            logic              locked_any;
            logic              egress_pop;
            logic              drop_pop;
            logic              dropping_reg;

            assign wr_word = {s_axis_tlast[gi],
                              s_axis_tid[gi*TID_WIDTH +: TID_WIDTH],
                              s_axis_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH],
                              s_axis_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH]};

            simple_1ck_fifo #(
                .WIDTH (WORD_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .resn    (resn),
                .wr_en   (s_axis_tvalid[gi] & s_axis_tready[gi]),
                .wr_data (wr_word),
                .rd_en   (fifo_pop[gi]),
                .rd_data (head_word[gi]),
                .full    (fifo_full[gi]),
                .empty   (fifo_empty[gi])
            );

            assign head_last[gi] = head_word[gi][WORD_W-1];
            assign head_tid[gi*TID_WIDTH +: TID_WIDTH] = head_word[gi][TID_LO +: TID_WIDTH];
            assign bad_tid = ({1'b0, head_word[gi][TID_LO +: TID_WIDTH]} >= (TID_WIDTH+1)'(M_PORTS));

            // Which master (if any) owns this slave, and does it pop us now.
            always_comb begin
                locked_any = 1'b0;
                egress_pop = 1'b0;
                for (int m = 0; m < M_PORTS; m++) begin
                    if (m_locked[m] && (src_flat[m*SW +: SW] == SW'(gi))) begin
                        locked_any = 1'b1;
                        if (m_accept[m]) egress_pop = 1'b1;
                    end
                end
            end

            // Once a bad-destination packet starts draining, the rest of it
            // drains too, whatever tid its later beats carry.
            assign drop_pop = !fifo_empty[gi] && !locked_any && (dropping_reg || bad_tid);

            always_ff @(posedge clk) begin
                if (!resn) begin
                    dropping_reg <= 1'b0;
                end else if (drop_pop) begin
                    dropping_reg <= !head_last[gi];
                end
            end

            assign slave_locked[gi]   = locked_any;
            assign slave_dropping[gi] = dropping_reg;
            assign fifo_pop[gi]       = egress_pop | drop_pop;
            assign drop_last[gi]      = drop_pop & head_last[gi];
        end
    endgenerate

    // ---------------- per-master arbitration and egress ----------------
    generate
        for (gi = 0; gi < M_PORTS; gi++) begin : g_master
            logic [0:0]             state_reg;
            logic [SW-1:0]          src_reg;
            logic [S_PORTS-1:0]     req;
            logic [S_PORTS-1:0]     grant;
            logic                   take;
            logic                   valid;
            logic                   last;
            logic [TID_WIDTH-1:0]   tid;
            logic [TUSER_WIDTH-1:0] user;
            logic [TDATA_WIDTH-1:0] data;

            always_comb begin
                req = '0;
                for (int k = 0; k < S_PORTS; k++) begin
                    req[k] = !fifo_empty[k] && !slave_locked[k] && !slave_dropping[k] &&
                             (head_tid[k*TID_WIDTH +: TID_WIDTH] == TID_WIDTH'(gi));
                end
            end

            assign take = (state_reg == IDLE) && (|req);

            if (ARB_MODE == int'(ARB_FIXED_PRIORITY)) begin : g_prio
                // Isolate the lowest set request bit.
                assign grant = req & (~req + S_PORTS'(1));
            end else begin : g_rr
                round_robin_arbiter #(
                    .N (S_PORTS)
                ) u_arb (
                    .clk   (clk),
                    .resn  (resn),
                    .req   (req),
                    .take  (take),
                    .grant (grant)
                );
            end

            always_ff @(posedge clk) begin
                if (!resn) begin
                    state_reg <= IDLE;
                    src_reg   <= '0;
                end else if (state_reg == IDLE) begin
                    if (take) begin
                        state_reg <= LOCKED;
                        src_reg   <= SW'(one_hot_to_binary(32'(grant)));
                    end
                end else if (m_accept[gi] && last) begin
                    state_reg <= IDLE;
                end
            end

            always_comb begin
                valid = 1'b0;
                last  = 1'b0;
                tid   = '0;
                user  = '0;
                data  = '0;
                if (state_reg == LOCKED) begin
                    valid = !fifo_empty[src_reg];
                    last  = head_word[src_reg][WORD_W-1];
                    tid   = TID_WIDTH'(src_reg);
                    user  = head_word[src_reg][TDATA_WIDTH +: TUSER_WIDTH];
                    data  = head_word[src_reg][0 +: TDATA_WIDTH];
                end
            end

            assign m_axis_tvalid[gi]                            = valid;
            assign m_axis_tlast[gi]                             = last;
            assign m_axis_tid[gi*TID_WIDTH +: TID_WIDTH]        = tid;
            assign m_axis_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH]  = user;
            assign m_axis_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH]  = data;
            assign m_accept[gi]                                 = valid & m_axis_tready[gi];
            assign m_locked[gi]                                 = (state_reg == LOCKED);
            assign m_busy[gi]                                   = (state_reg == LOCKED);
            assign src_flat[gi*SW +: SW]                        = src_reg;
        end
    endgenerate

    // ---------------- dropped-packet counter ----------------
    // Several slaves may finish dropping in the same cycle; 17 bits cannot
    // overflow for up to 32 slaves, so saturation is applied once.
    always_comb begin
        drop_sum = {1'b0, drop_count_reg};
        for (int f = 0; f < S_PORTS; f++) begin
            drop_sum = drop_sum + 17'(drop_last[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            drop_count_reg <= '0;
        end else begin
            drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_axis_packet_switch.sv
// Directed testbench for axis_packet_switch (4x4, 8-deep FIFOs, round-robin).
module tb_axis_packet_switch;
    localparam int S  = 4;
    localparam int M  = 4;
    localparam int TW = 8;
    localparam int UW = 8;
    localparam int DW = 8;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            resn;
    logic [S*TW-1:0] s_tid;
    logic [S*UW-1:0] s_tuser;
    logic [S*DW-1:0] s_tdata;
    logic [S-1:0]    s_tvalid;
    logic [S-1:0]    s_tlast;
    logic [S-1:0]    s_tready;
    logic [M*TW-1:0] m_tid;
    logic [M*UW-1:0] m_tuser;
    logic [M*DW-1:0] m_tdata;
    logic [M-1:0]    m_tvalid;
    logic [M-1:0]    m_tlast;
    logic [M-1:0]    m_tready;
    logic [M-1:0]    m_busy;
    logic [15:0]     drop_count;

    always #5 clk = ~clk;

    axis_packet_switch #(
        .S_PORTS(S), .M_PORTS(M), .TID_WIDTH(TW), .TUSER_WIDTH(UW),
        .TDATA_WIDTH(DW), .FIFO_DEPTH(D), .ARB_MODE(0)
    ) dut (
        .clk(clk), .resn(resn),
        .s_axis_tid(s_tid), .s_axis_tuser(s_tuser), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tid(m_tid), .m_axis_tuser(m_tuser), .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .m_busy(m_busy), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [7:0]  m;
        logic [7:0]  tid;
        logic [7:0]  data;
        logic        last;
        logic [31:0] cyc;
    } beat_t;

    beat_t obs_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    logic [7:0] t2_data [8] = '{8'hA1, 8'hA2, 8'hC1, 8'hC2, 8'hB1, 8'hB2, 8'hD1, 8'hD2};
    logic [7:0] t2_tid  [8] = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd1, 8'd1, 8'd3, 8'd3};

    always @(posedge clk) cyc <= cyc + 1;

    // Beats seen valid&ready at the falling edge are accepted on the next rise.
    always @(negedge clk) begin
        for (int m = 0; m < M; m++) begin
            if (m_tvalid[m] && m_tready[m]) begin
                beat_t b;
                b.m    = 8'(m);
                b.tid  = m_tid[m*TW +: TW];
                b.data = m_tdata[m*DW +: DW];
                b.last = m_tlast[m];
                b.cyc  = 32'(cyc);
                obs_q.push_back(b);
                $display("beat m%0d tid=%0d data=%02h last=%0b cyc=%0d", m, b.tid, b.data, b.last, cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic set_beat(input int s, input logic [7:0] tid, input logic [7:0] data, input logic last);
        s_tvalid[s]          = 1'b1;
        s_tlast[s]           = last;
        s_tid[s*TW +: TW]    = tid;
        s_tdata[s*DW +: DW]  = data;
        s_tuser[s*UW +: UW]  = data ^ 8'hFF;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 32'(obs_q.size()), 32'(n));
    endtask

    task automatic wait_ready(input int s, input string tag);
        int k;
        k = 0;
        while (!s_tready[s] && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(s_tready[s]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resn     = 1'b0;
        s_tid    = '0;
        s_tuser  = '0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = '1;
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_s_tready", 32'(s_tready), 32'h0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_m_busy", 32'(m_busy), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        resn = 1'b1;
        tick();
        chk("post_rst_s_tready", 32'(s_tready), 32'hF);

        // ---- T1: slave0 -> m2, 3 beats ----
        obs_q.delete();
        set_beat(0, 8'd2, 8'h11, 1'b0);
        tick();
        chk("t1_busy_before_lock", 32'(m_busy[2]), 32'd0);
        set_beat(0, 8'd2, 8'h22, 1'b0);
        tick();
        chk("t1_busy_locked", 32'(m_busy[2]), 32'd1);
        chk("t1_tvalid", 32'(m_tvalid[2]), 32'd1);
        chk("t1_first_data", 32'(m_tdata[2*DW +: DW]), 32'h11);
        chk("t1_tuser", 32'(m_tuser[2*UW +: UW]), 32'hEE);
        chk("t1_tid", 32'(m_tid[2*TW +: TW]), 32'd0);
        set_beat(0, 8'd2, 8'h33, 1'b1);
        tick();
        wait_beats(3, "t1_count");
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            chk("t1_m", 32'(obs_q[i].m), 32'd2);
            chk("t1_data", 32'(obs_q[i].data), 32'h11 * (i + 1));
            chk("t1_last", 32'(obs_q[i].last), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("t1_busy_after", 32'(m_busy[2]), 32'd0);
        chk("t1_idle_data", 32'(m_tdata[2*DW +: DW]), 32'h0);

        // ---- T2: slaves 1 and 3 -> m0, two packets each, round-robin ----
        obs_q.delete();
        set_beat(1, 8'd0, 8'hA1, 1'b0); set_beat(3, 8'd0, 8'hC1, 1'b0); tick();
        set_beat(1, 8'd0, 8'hA2, 1'b1); set_beat(3, 8'd0, 8'hC2, 1'b1); tick();
        set_beat(1, 8'd0, 8'hB1, 1'b0); set_beat(3, 8'd0, 8'hD1, 1'b0); tick();
        set_beat(1, 8'd0, 8'hB2, 1'b1); set_beat(3, 8'd0, 8'hD2, 1'b1); tick();
        wait_beats(8, "t2_count");
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            chk("t2_data", 32'(obs_q[i].data), 32'(t2_data[i]));
            chk("t2_src", 32'(obs_q[i].tid), 32'(t2_tid[i]));
        end

        // ---- T3: slave0 -> m1 and slave2 -> m3 concurrently ----
        tick();
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_beat(0, 8'd1, 8'(8'h60 + i), i == 3);
            set_beat(2, 8'd3, 8'(8'h70 + i), i == 3);
            tick();
        end
        wait_beats(8, "t3_count");
        if (obs_q.size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_m_a", 32'(obs_q[2*i].m), 32'd1);
                chk("t3_data_a", 32'(obs_q[2*i].data), 32'h60 + 32'(i));
                chk("t3_m_b", 32'(obs_q[2*i+1].m), 32'd3);
                chk("t3_data_b", 32'(obs_q[2*i+1].data), 32'h70 + 32'(i));
                chk("t3_parallel", obs_q[2*i+1].cyc, obs_q[2*i].cyc);
                chk("t3_rate", obs_q[2*i].cyc, obs_q[0].cyc + 32'(i));
            end
        end

        // ---- T4: backpressure on m0 fills slave0's FIFO ----
        tick();
        obs_q.delete();
        m_tready[0] = 1'b0;
        for (int i = 0; i < D; i++) begin
            chk("t4_ready_fill", 32'(s_tready[0]), 32'd1);
            set_beat(0, 8'd0, 8'(8'h40 + i), 1'b0);
            tick();
        end
        chk("t4_ready_full", 32'(s_tready[0]), 32'd0);
        chk("t4_held", 32'(obs_q.size()), 32'd0);
        m_tready[0] = 1'b1;
        for (int i = D; i < D + 2; i++) begin
            wait_ready(0, "t4_ready_return");
            set_beat(0, 8'd0, 8'(8'h40 + i), i == D + 1);
            tick();
        end
        wait_beats(D + 2, "t4_count");
        for (int i = 0; i < D + 2 && i < obs_q.size(); i++) begin
            chk("t4_data", 32'(obs_q[i].data), 32'h40 + 32'(i));
            chk("t4_last", 32'(obs_q[i].last), (i == D + 1) ? 32'd1 : 32'd0);
        end

        // ---- T5: bad destination dropped, then a good packet ----
        tick();
        obs_q.delete();
        chk("t5_drop_before", 32'(drop_count), 32'd0);
        set_beat(1, 8'd7, 8'h81, 1'b0); tick();
        set_beat(1, 8'd7, 8'h82, 1'b1); tick();
        set_beat(1, 8'd2, 8'h51, 1'b0); tick();
        set_beat(1, 8'd2, 8'h52, 1'b1); tick();
        wait_beats(2, "t5_count");
        chk("t5_drop_after", 32'(drop_count), 32'd1);
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            chk("t5_m", 32'(obs_q[i].m), 32'd2);
            chk("t5_src", 32'(obs_q[i].tid), 32'd1);
            chk("t5_data", 32'(obs_q[i].data), 32'h51 + 32'(i));
        end

        // ---- T6: reset mid-packet, then a fresh packet ----
        tick();
        set_beat(0, 8'd1, 8'h91, 1'b0); tick();
        set_beat(0, 8'd1, 8'h92, 1'b0); tick();
        chk("t6_busy_mid", 32'(m_busy[1]), 32'd1);
        tick();
        resn = 1'b0;
        tick();
        chk("t6_rst_tvalid", 32'(m_tvalid), 32'h0);
        chk("t6_rst_busy", 32'(m_busy), 32'h0);
        chk("t6_rst_tdata", m_tdata, 32'h0);
        chk("t6_rst_tlast", 32'(m_tlast), 32'h0);
        chk("t6_rst_drop", 32'(drop_count), 32'h0);
        chk("t6_rst_s_tready", 32'(s_tready), 32'h0);
        resn = 1'b1;
        tick();
        chk("t6_ready_after", 32'(s_tready), 32'hF);
        obs_q.delete();
        set_beat(0, 8'd1, 8'h77, 1'b1); tick();
        wait_beats(1, "t6_count");
        if (obs_q.size() >= 1) begin
            chk("t6_m", 32'(obs_q[0].m), 32'd1);
            chk("t6_src", 32'(obs_q[0].tid), 32'd0);
            chk("t6_data", 32'(obs_q[0].data), 32'h77);
            chk("t6_last", 32'(obs_q[0].last), 32'd1);
        end
        repeat (3) tick();
        chk("t6_no_stale", 32'(obs_q.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
